golden_nonce_tx_queue: RTL
==========================

Name: golden_nonce_tx_queue

Overview:
- Downstream consumer of the miner's golden-nonce output.
- Runs in the UART comm_clk domain. Nonce pulses arrive already synchronised into that domain.
- Buffers each found 32-bit nonce in a small FIFO, then serialises it into a byte stream over a valid/ready handshake to the UART transmitter.
- Nonces found back-to-back while the UART is busy are queued, not lost.

Parameters:
- DEPTH, 8: FIFO entries in nonce words. Power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width. Derived; not overridden.

Ports:
- comm_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- nonce_in  in  32  golden nonce. Sampled only when nonce_valid=1.
- nonce_valid  in  1  single-cycle strobe, one per found nonce.
- flush  in  1  synchronous clear of queue, frame in flight and overflow flag.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts the byte this cycle.
- fifo_count  out  CNT_W  stored nonces, excluding the frame being sent.
- overflow  out  1  sticky: at least one nonce was dropped.

Behaviour:
- Reset values (asynchronous): tx_data=0, tx_valid=0, fifo_count=0, overflow=0. FSM=IDLE, read/write pointers=0.
- Push: when nonce_valid=1 and (fifo_count<DEPTH or a pop occurs this cycle), nonce_in is written at the rising edge.
- Drop: when nonce_valid=1 with fifo_count==DEPTH and no pop this cycle, the nonce is discarded and overflow is set. overflow stays set until flush or reset.
- Pointers wrap modulo DEPTH. fifo_count is unchanged on simultaneous push and pop.
- FSM states IDLE, SEND.
  - IDLE: if fifo_count>0, pop the head into a 32-bit shift register, set byte_idx=0, go to SEND. tx_valid=0 while in IDLE.
  - SEND: tx_valid=1 and tx_data = byte byte_idx.
  - Byte order is LSB first: byte0=nonce[7:0] ... byte3=nonce[31:24].
  - Each byte advances on a tx_valid && tx_ready edge.
  - After the last byte is accepted: if fifo_count>0, pop the next nonce in that same cycle and stay in SEND with byte_idx=0, giving zero-bubble frames. Otherwise return to IDLE.
- Handshake: while tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. tx_ready is ignored when tx_valid=0.
- Latency: a nonce_valid edge into an empty queue with the FSM in IDLE gives fifo_count=1 in the next cycle. tx_valid rises one cycle after that (2 cycles after the strobe). fifo_count returns to 0 as the pop occurs.
- Frame length: FRAME_BYTES=4, or 5 with the optional feature.
- flush has priority over all other activity in the same cycle:
  - pointers and count cleared; overflow cleared;
  - FSM goes to IDLE and tx_valid=0 in the next cycle, aborting a partial frame;
  - a nonce_valid arriving in the same cycle is discarded.
- Reset asserted mid-frame aborts immediately. No partial frame resumes after reset.

Optional Feature:
- Macro: GOLDEN_NONCE_CHECKSUM_EN.
- When defined: each frame is 5 bytes. The 5th byte = byte0^byte1^byte2^byte3. It is accumulated during SEND and presented under the same handshake rules.
- When undefined: frames are 4 bytes with no checksum logic.
- The host parser reads the same macro via the shared definitions file.

Decomposition:
- Shared definitions file golden_tx_defs:
  - FRAME_BYTES (4/5 per macro);
  - NONCE_W=32;
  - FSM state encodings ST_IDLE=0, ST_SEND=1;
  - byte-order constant (LSB_FIRST).
- One sub-module: nonce_sync_fifo.
  - Contents: synchronous FIFO with width and depth parameters, push/pop/full/empty/count outputs, and flush.
  - Top level: the FSM, shift register and drop/overflow logic.

Test Plan:
- Single nonce: nonce_in=0xDEADBEEF strobe, tx_ready=1 → tx_valid rises 2 cycles later. Bytes EF,BE,AD,DE on consecutive cycles. With the macro, a 5th byte 0x22. tx_valid then drops and fifo_count=0.
- Backpressure: tx_ready=0 for 10 cycles mid-frame → tx_data stable at the current byte throughout. The sequence resumes correctly and no byte is duplicated or skipped.
- Burst: tx_ready=0, push 0x00000001..0x00000003 on consecutive cycles → fifo_count reaches 2, with one frame already loaded. Releasing tx_ready gives 12 bytes (15 with the macro) back-to-back with no bubble, in order.
- Overflow: tx_ready=0, push DEPTH+2 nonces → fifo_count==DEPTH and overflow=1. Output order matches the first DEPTH+1 pushes; the last push is dropped.
- Full with simultaneous pop: queue full, pop cycle coincides with nonce_valid → push accepted, overflow stays 0, fifo_count stays DEPTH.
- Flush/reset mid-frame: flush after byte1 accepted → tx_valid=0 next cycle, fifo_count=0, overflow=0. Then push 0x12345678 → frame 78,56,34,12. Repeat with reset_n pulsed low asynchronously → all outputs zero immediately.

Source files
------------

// File: rtl/golden_nonce_tx_queue_pkg.sv
// Shared definitions for the golden-nonce transmit path.
// The host-side parser reads the same values, so the frame format is defined here only.
//   NONCE_W     : nonce word width
//   FRAME_BYTES : bytes per UART frame (4, or 5 when GOLDEN_NONCE_CHECKSUM_EN adds an XOR byte)
//   LSB_FIRST   : byte order of the nonce on the wire
//   state_t     : serialiser FSM states
// Macro: GOLDEN_NONCE_CHECKSUM_EN
package golden_nonce_tx_queue_pkg;

    localparam int unsigned NONCE_W = 32;

`ifdef GOLDEN_NONCE_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = 5;
`else
    localparam int unsigned FRAME_BYTES = 4;
`endif

    localparam bit LSB_FIRST = 1'b1;

    // Wide enough to index the longest frame (5 bytes).
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/golden_nonce_tx_queue_if.sv
// Byte-stream handshake from the nonce queue to the UART transmitter.
//   tx_data  : byte presented to the UART
//   tx_valid : tx_data is valid
//   tx_ready : UART accepts the byte this cycle
// master = byte producer (queue), slave = UART transmitter.
interface golden_nonce_tx_queue_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/nonce_sync_fifo.sv
// Single-clock FIFO holding found nonces.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of pointers and count (wins over push/pop)
//   push/wdata : write request; accepted when not full or when a pop happens this cycle
//   pop/rdata  : read request; rdata always shows the head entry
//   full/empty/count : occupancy status
module nonce_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still takes a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/golden_nonce_tx_queue.sv
// Golden-nonce transmit queue (comm_clk domain).
// Buffers found nonces in a FIFO and serialises each one as a byte frame
// to the UART transmitter, LSB first, with back-to-back frames when more
// nonces are waiting.
//   comm_clk, reset_n : clock, asynchronous active-low reset
//   nonce_in/nonce_valid : one-cycle strobe per found nonce
//   flush      : clears queue, frame in flight and overflow flag
//   tx         : byte handshake to the UART (master side)
//   fifo_count : stored nonces, not counting the frame being sent
//   overflow   : sticky, a nonce was dropped because the queue was full
// Macro: GOLDEN_NONCE_CHECKSUM_EN appends an XOR checksum byte to each frame.
module golden_nonce_tx_queue
    import golden_nonce_tx_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    comm_clk,
    input  logic                    reset_n,
    input  logic [NONCE_W-1:0]      nonce_in,
    input  logic                    nonce_valid,
    input  logic                    flush,
    golden_nonce_tx_queue_if.master tx,
    output logic [CNT_W-1:0]        fifo_count,
    output logic                    overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    state_t             state;
    state_t             state_nx;
    logic [NONCE_W-1:0] shreg;
    logic [NONCE_W-1:0] shreg_nx;
    logic [IDX_W-1:0]   byte_idx;
    logic [IDX_W-1:0]   byte_idx_nx;
    logic [7:0]         cur_byte;
    logic               load;
    logic               drop;

    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [NONCE_W-1:0] fifo_head;

`ifdef GOLDEN_NONCE_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_nx;
`endif

    nonce_sync_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (comm_clk),
        .rst_n (reset_n),
        .flush (flush),
        .push  (nonce_valid),
        .wdata (nonce_in),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The outgoing byte always sits at the shift end of the register.
    assign cur_byte = LSB_FIRST ? shreg[7:0] : shreg[NONCE_W-1 -: 8];

    assign drop = nonce_valid && fifo_full && !fifo_pop && !flush;

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        byte_idx_nx = byte_idx;
        fifo_pop    = 1'b0;
        load        = 1'b0;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
        csum_nx     = csum;
`endif
        case (state)
            ST_IDLE: begin
                load = !fifo_empty;
            end
            ST_SEND: begin
                if (tx.tx_ready) begin
                    if (byte_idx == LAST_IDX) begin
                        // Reload in the same cycle so frames run without a bubble.
                        load = !fifo_empty;
                        if (fifo_empty) begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        shreg_nx    = LSB_FIRST ? (shreg >> 8) : (shreg << 8);
                        byte_idx_nx = byte_idx + 1'b1;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
                        csum_nx     = csum ^ cur_byte;
`endif
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (load) begin
            fifo_pop    = 1'b1;
            shreg_nx    = fifo_head;
            byte_idx_nx = '0;
            state_nx    = ST_SEND;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
            csum_nx     = '0;
`endif
        end

        // Flush aborts any frame and suppresses the pop.
        if (flush) begin
            fifo_pop    = 1'b0;
            shreg_nx    = '0;
            byte_idx_nx = '0;
            state_nx    = ST_IDLE;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
            csum_nx     = '0;
`endif
        end
    end

    always_ff @(posedge comm_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            byte_idx <= '0;
            overflow <= 1'b0;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            byte_idx <= byte_idx_nx;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
            csum     <= csum_nx;
`endif
            if (flush) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign tx.tx_valid = (state == ST_SEND);

    always_comb begin
        tx.tx_data = '0;
        if (state == ST_SEND) begin
`ifdef GOLDEN_NONCE_CHECKSUM_EN
            tx.tx_data = (byte_idx == LAST_IDX) ? csum : cur_byte;
`else
            tx.tx_data = cur_byte;
`endif
        end
    end

endmodule
